hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-index width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, legal 1..4, load-use stall cycles per hazard.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- memread_idex  in  1  ID/EX instruction is a load.
- rd_idex  in  REG_AW  ID/EX destination.
- rs1_ifid, rs2_ifid  in  REG_AW  IF/ID sources.
- rs1_used_ifid, rs2_used_ifid  in  1  source actually read.
- rs1_idex, rs2_idex  in  REG_AW  ID/EX sources, for forwarding.
- regwrite_exmem  in  1  EX/MEM writes a register.
- rd_exmem  in  REG_AW  EX/MEM destination.
- regwrite_memwb  in  1  MEM/WB writes a register.
- rd_memwb  in  REG_AW  MEM/WB destination.
- branch_taken_ex  in  1  branch/jump resolved taken in EX.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID load enable.
- idex_bubble  out  1  insert NOP into ID/EX.
- ifid_flush  out  1  clear IF/ID.
- fwd_a, fwd_b  out  2  operand A/B forward select.
- stall_count  out  CNT_W  total stall cycles since reset.

Function
REQ-005 SHALL define load-use hazard as memread_idex=1, rd_idex!=0, and (rs1_used_ifid and rs1_ifid==rd_idex, or rs2_used_ifid and rs2_ifid==rd_idex).
REQ-006 SHALL implement FSM with states RUN and STALL; the state register and remaining-cycle counter are the only control state.
REQ-007 In RUN, with no hazard and no branch, outputs SHALL be pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
REQ-008 In RUN, on a hazard, outputs SHALL be pc_write=0, ifid_write=0, idex_bubble=1 in the same cycle, combinationally.
REQ-009 On a RUN hazard with LOAD_LAT>1, the FSM SHALL enter STALL with remaining counter = LOAD_LAT-2; with LOAD_LAT=1 it SHALL stay in RUN.
REQ-010 In STALL, outputs SHALL equal REQ-008 regardless of hazard inputs.
REQ-011 In STALL, the counter SHALL decrement each cycle and the FSM SHALL return to RUN after the cycle in which the counter is 0; each hazard thus gives exactly LOAD_LAT stall cycles.
REQ-012 branch_taken_ex=1 SHALL override everything in any state: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, next state RUN, counter 0.
REQ-013 fwd_a SHALL be 2'b10 if regwrite_exmem and rd_exmem!=0 and rd_exmem==rs1_idex; else 2'b01 if regwrite_memwb and rd_memwb!=0 and rd_memwb==rs1_idex; else 2'b00. fwd_b SHALL use the same rule with rs2_idex.
REQ-014 Forwarding SHALL be purely combinational, independent of FSM state; EX/MEM SHALL win when both stages match.
REQ-015 stall_count SHALL increment by 1 on every clock edge where pc_write=0 and SHALL saturate at all-ones.
REQ-016 Register index 0 SHALL never cause a stall or a forward.

Reset
REQ-017 rst=1 SHALL asynchronously force state RUN, counter 0, stall_count 0.
REQ-018 While rst=1, outputs SHALL be pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, fwd_a=fwd_b=00.
REQ-019 Asserting rst mid-STALL SHALL abort the stall immediately; after release the block SHALL start in RUN.

Structure
REQ-020 Package hazard_pkg SHALL hold the FSM state encoding and the forward-select constants FWD_NONE=00, FWD_MEMWB=01, FWD_EXMEM=10.
REQ-021 One sub-module, fwd_select, SHALL compute one operand's select per REQ-013 and SHALL be instantiated twice.

Verification
REQ-022 LOAD_LAT=1, memread_idex=1, rd_idex=5, rs1_ifid=5, rs1_used_ifid=1 -> one cycle with pc_write=0, idex_bubble=1; stall_count becomes 1.
REQ-023 LOAD_LAT=3, same hazard held for one cycle -> exactly 3 consecutive stall cycles, then RUN; stall_count becomes 3.
REQ-024 LOAD_LAT=3, branch_taken_ex=1 in the 2nd stall cycle -> that cycle ifid_flush=1, pc_write=1; the next cycle is RUN with no stall.
REQ-025 rd_exmem=rd_memwb=7, both regwrite=1, rs1_idex=7 -> fwd_a=10; with rd_idex=0 and rs1_ifid=0 on a load -> no stall.
REQ-026 rst pulsed during the 2nd of 4 stall cycles (LOAD_LAT=4) -> outputs are at reset values immediately; stall_count=0 after release.
REQ-027 CNT_W=2 and 5 stall cycles -> stall_count holds at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard controller
// Contents:
//   state_e        : FSM encoding (ST_RUN, ST_STALL)
//   FWD_*          : operand forward-select codes
//   REM_W          : width of the remaining-stall-cycle counter (LOAD_LAT <= 4)
package hazard_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // Largest preload is LOAD_LAT-2 = 2, so two bits suffice.
    localparam int REM_W = 2;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - forward-select decode for one EX operand
// Ports:
//   regwrite_exmem, rd_exmem : EX/MEM write enable and destination
//   regwrite_memwb, rd_memwb : MEM/WB write enable and destination
//   rs_idex                  : ID/EX source register of this operand
//   fwd                      : FWD_EXMEM / FWD_MEMWB / FWD_NONE
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              regwrite_exmem,
    input  logic [REG_AW-1:0] rd_exmem,
    input  logic              regwrite_memwb,
    input  logic [REG_AW-1:0] rd_memwb,
    input  logic [REG_AW-1:0] rs_idex,
    output logic [1:0]        fwd
);

    logic hit_exmem;
    logic hit_memwb;

    // x0 is hardwired zero, so a write to it never supplies a value.
    assign hit_exmem = regwrite_exmem && (rd_exmem != '0) && (rd_exmem == rs_idex);
    assign hit_memwb = regwrite_memwb && (rd_memwb != '0) && (rd_memwb == rs_idex);

    // EX/MEM holds the younger result, so it takes priority.
    always_comb begin
        fwd = FWD_NONE;
        if (hit_exmem) begin
            fwd = FWD_EXMEM;
        end else if (hit_memwb) begin
            fwd = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch flush and forwarding control
// Ports:
//   clk, rst                         : clock, async active-high reset
//   memread_idex, rd_idex            : load in ID/EX and its destination
//   rs1/rs2_ifid, rs1/rs2_used_ifid  : IF/ID sources and their use flags
//   rs1/rs2_idex                     : ID/EX sources for forwarding
//   regwrite_exmem/memwb, rd_*       : later-stage writers
//   branch_taken_ex                  : taken branch/jump resolved in EX
//   pc_write, ifid_write             : pipeline front-end enables
//   idex_bubble, ifid_flush          : NOP insert into ID/EX, IF/ID clear
//   fwd_a, fwd_b                     : operand forward selects
//   stall_count                      : saturating count of stalled cycles
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memread_idex,
    input  logic [REG_AW-1:0] rd_idex,
    input  logic [REG_AW-1:0] rs1_ifid,
    input  logic [REG_AW-1:0] rs2_ifid,
    input  logic              rs1_used_ifid,
    input  logic              rs2_used_ifid,
    input  logic [REG_AW-1:0] rs1_idex,
    input  logic [REG_AW-1:0] rs2_idex,
    input  logic              regwrite_exmem,
    input  logic [REG_AW-1:0] rd_exmem,
    input  logic              regwrite_memwb,
    input  logic [REG_AW-1:0] rd_memwb,
    input  logic              branch_taken_ex,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_count
);

    // The RUN cycle that detects the hazard is the first stall cycle, so
    // STALL only has to cover the remaining LOAD_LAT-1 cycles.
    localparam int STALL_INIT = (LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0;

    state_e             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   stall_count_q;
    logic               load_use;
    logic [1:0]         fwd_a_raw;
    logic [1:0]         fwd_b_raw;

    assign load_use = memread_idex && (rd_idex != '0) &&
                      ((rs1_used_ifid && (rs1_ifid == rd_idex)) ||
                       (rs2_used_ifid && (rs2_ifid == rd_idex)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;

        if (rst) begin
            // Outputs are held at their idle values while reset is applied.
            state_d = ST_RUN;
            rem_d   = '0;
        end else if (branch_taken_ex) begin
            // The wrong-path instructions are squashed; the front end must
            // keep moving to fetch the target, so stall is abandoned.
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            state_d     = ST_RUN;
            rem_d       = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = ST_STALL;
                            rem_d   = REM_W'(STALL_INIT);
                        end
                    end
                end
                ST_STALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (rem_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        rem_d = rem_q - REM_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    rem_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
        end else if (!pc_write && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_count_q;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .regwrite_exmem (regwrite_exmem),
        .rd_exmem       (rd_exmem),
        .regwrite_memwb (regwrite_memwb),
        .rd_memwb       (rd_memwb),
        .rs_idex        (rs1_idex),
        .fwd            (fwd_a_raw)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .regwrite_exmem (regwrite_exmem),
        .rd_exmem       (rd_exmem),
        .regwrite_memwb (regwrite_memwb),
        .rd_memwb       (rd_memwb),
        .rs_idex        (rs2_idex),
        .fwd            (fwd_b_raw)
    );

    assign fwd_a = rst ? FWD_NONE : fwd_a_raw;
    assign fwd_b = rst ? FWD_NONE : fwd_b_raw;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       memread_idex = 1'b0;
    logic [4:0] rd_idex = '0;
    logic [4:0] rs1_ifid = '0, rs2_ifid = '0;
    logic       rs1_used_ifid = 1'b0, rs2_used_ifid = 1'b0;
    logic [4:0] rs1_idex = '0, rs2_idex = '0;
    logic       regwrite_exmem = 1'b0, regwrite_memwb = 1'b0;
    logic [4:0] rd_exmem = '0, rd_memwb = '0;
    logic       branch_taken_ex = 1'b0;

    logic pc1, ifw1, bub1, fl1;  logic [1:0] fa1, fb1;  logic [15:0] sc1;
    logic pc3, ifw3, bub3, fl3;  logic [1:0] fa3, fb3;  logic [15:0] sc3;
    logic pc4, ifw4, bub4, fl4;  logic [1:0] fa4, fb4;  logic [15:0] sc4;
    logic pcc, ifwc, bubc, flc;  logic [1:0] fac, fbc;  logic [1:0]  scc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
        .clk(clk), .rst(rst), .memread_idex(memread_idex), .rd_idex(rd_idex),
        .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid), .rs1_used_ifid(rs1_used_ifid),
        .rs2_used_ifid(rs2_used_ifid), .rs1_idex(rs1_idex), .rs2_idex(rs2_idex),
        .regwrite_exmem(regwrite_exmem), .rd_exmem(rd_exmem),
        .regwrite_memwb(regwrite_memwb), .rd_memwb(rd_memwb),
        .branch_taken_ex(branch_taken_ex), .pc_write(pc1), .ifid_write(ifw1),
        .idex_bubble(bub1), .ifid_flush(fl1), .fwd_a(fa1), .fwd_b(fb1), .stall_count(sc1));

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
        .clk(clk), .rst(rst), .memread_idex(memread_idex), .rd_idex(rd_idex),
        .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid), .rs1_used_ifid(rs1_used_ifid),
        .rs2_used_ifid(rs2_used_ifid), .rs1_idex(rs1_idex), .rs2_idex(rs2_idex),
        .regwrite_exmem(regwrite_exmem), .rd_exmem(rd_exmem),
        .regwrite_memwb(regwrite_memwb), .rd_memwb(rd_memwb),
        .branch_taken_ex(branch_taken_ex), .pc_write(pc3), .ifid_write(ifw3),
        .idex_bubble(bub3), .ifid_flush(fl3), .fwd_a(fa3), .fwd_b(fb3), .stall_count(sc3));

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(4), .CNT_W(16)) u_lat4 (
        .clk(clk), .rst(rst), .memread_idex(memread_idex), .rd_idex(rd_idex),
        .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid), .rs1_used_ifid(rs1_used_ifid),
        .rs2_used_ifid(rs2_used_ifid), .rs1_idex(rs1_idex), .rs2_idex(rs2_idex),
        .regwrite_exmem(regwrite_exmem), .rd_exmem(rd_exmem),
        .regwrite_memwb(regwrite_memwb), .rd_memwb(rd_memwb),
        .branch_taken_ex(branch_taken_ex), .pc_write(pc4), .ifid_write(ifw4),
        .idex_bubble(bub4), .ifid_flush(fl4), .fwd_a(fa4), .fwd_b(fb4), .stall_count(sc4));

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(2)) u_cnt2 (
        .clk(clk), .rst(rst), .memread_idex(memread_idex), .rd_idex(rd_idex),
        .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid), .rs1_used_ifid(rs1_used_ifid),
        .rs2_used_ifid(rs2_used_ifid), .rs1_idex(rs1_idex), .rs2_idex(rs2_idex),
        .regwrite_exmem(regwrite_exmem), .rd_exmem(rd_exmem),
        .regwrite_memwb(regwrite_memwb), .rd_memwb(rd_memwb),
        .branch_taken_ex(branch_taken_ex), .pc_write(pcc), .ifid_write(ifwc),
        .idex_bubble(bubc), .ifid_flush(flc), .fwd_a(fac), .fwd_b(fbc), .stall_count(scc));

    task automatic idle_inputs();
        memread_idex = 0; rd_idex = 0; rs1_ifid = 0; rs2_ifid = 0;
        rs1_used_ifid = 0; rs2_used_ifid = 0; rs1_idex = 0; rs2_idex = 0;
        regwrite_exmem = 0; rd_exmem = 0; regwrite_memwb = 0; rd_memwb = 0;
        branch_taken_ex = 0;
    endtask

    task automatic set_load_use_r5();
        memread_idex = 1; rd_idex = 5'd5; rs1_ifid = 5'd5; rs1_used_ifid = 1;
    endtask

    // Leaves time at posedge+2: inputs may be changed, then #1 before sampling.
    task automatic pulse_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1;
        set_load_use_r5();
        regwrite_exmem = 1; rd_exmem = 5'd7; rs1_idex = 5'd7; rs2_idex = 5'd7;
        #1;
        n_checks++; if ({pc4, ifw4, bub4, fl4} !== 4'b1100) begin n_fail++;
            $display("FAIL reset_ctrl: got %b want 1100", {pc4, ifw4, bub4, fl4}); end
        n_checks++; if ({fa1, fb1} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_fwd: got %b want 0000", {fa1, fb1}); end
        @(posedge clk); #1;
        n_checks++; if (sc1 !== 16'd0) begin n_fail++;
            $display("FAIL reset_count: got %0d want 0", sc1); end
        rst = 0;
        idle_inputs();
        #1;
        n_checks++; if ({pc1, ifw1, bub1, fl1} !== 4'b1100) begin n_fail++;
            $display("FAIL run_idle: got %b want 1100", {pc1, ifw1, bub1, fl1}); end
    endtask

    task automatic test_lat1();
        pulse_reset();
        set_load_use_r5();
        #1;
        n_checks++; if ({pc1, ifw1, bub1, fl1} !== 4'b0010) begin n_fail++;
            $display("FAIL lat1_stall: got %b want 0010", {pc1, ifw1, bub1, fl1}); end
        next_cycle();
        idle_inputs();
        #1;
        n_checks++; if (pc1 !== 1'b1) begin n_fail++;
            $display("FAIL lat1_resume: got %b want 1", pc1); end
        n_checks++; if (sc1 !== 16'd1) begin n_fail++;
            $display("FAIL lat1_count: got %0d want 1", sc1); end
    endtask

    task automatic test_lat3();
        pulse_reset();
        set_load_use_r5();
        #1;
        n_checks++; if (pc3 !== 1'b0) begin n_fail++;
            $display("FAIL lat3_c0: got %b want 0", pc3); end
        next_cycle();
        idle_inputs();
        #1;
        n_checks++; if ({pc3, ifw3, bub3} !== 3'b001) begin n_fail++;
            $display("FAIL lat3_c1: got %b want 001", {pc3, ifw3, bub3}); end
        next_cycle();
        #1;
        n_checks++; if ({pc3, ifw3, bub3} !== 3'b001) begin n_fail++;
            $display("FAIL lat3_c2: got %b want 001", {pc3, ifw3, bub3}); end
        next_cycle();
        #1;
        n_checks++; if ({pc3, ifw3, bub3} !== 3'b110) begin n_fail++;
            $display("FAIL lat3_c3_run: got %b want 110", {pc3, ifw3, bub3}); end
        n_checks++; if (sc3 !== 16'd3) begin n_fail++;
            $display("FAIL lat3_count: got %0d want 3", sc3); end
        n_checks++; if (pc4 !== 1'b0 || sc4 !== 16'd3) begin n_fail++;
            $display("FAIL lat4_c3: got pc=%b cnt=%0d want pc=0 cnt=3", pc4, sc4); end
        next_cycle();
        #1;
        n_checks++; if (pc4 !== 1'b1 || sc4 !== 16'd4) begin n_fail++;
            $display("FAIL lat4_done: got pc=%b cnt=%0d want pc=1 cnt=4", pc4, sc4); end
    endtask

    task automatic test_branch();
        pulse_reset();
        set_load_use_r5();
        next_cycle();
        idle_inputs();
        branch_taken_ex = 1;
        #1;
        n_checks++; if ({pc3, ifw3, bub3, fl3} !== 4'b1111) begin n_fail++;
            $display("FAIL br_flush: got %b want 1111", {pc3, ifw3, bub3, fl3}); end
        next_cycle();
        branch_taken_ex = 0;
        #1;
        n_checks++; if ({pc3, bub3, fl3} !== 3'b100) begin n_fail++;
            $display("FAIL br_after: got %b want 100", {pc3, bub3, fl3}); end
        n_checks++; if (sc3 !== 16'd1) begin n_fail++;
            $display("FAIL br_count: got %0d want 1", sc3); end
    endtask

    task automatic test_forwarding();
        pulse_reset();
        regwrite_exmem = 1; rd_exmem = 5'd7; regwrite_memwb = 1; rd_memwb = 5'd7;
        rs1_idex = 5'd7; rs2_idex = 5'd3;
        #1;
        n_checks++; if ({fa1, fb1} !== 4'b1000) begin n_fail++;
            $display("FAIL fwd_exmem_wins: got %b want 1000", {fa1, fb1}); end
        rd_memwb = 5'd3;
        #1;
        n_checks++; if ({fa1, fb1} !== 4'b1001) begin n_fail++;
            $display("FAIL fwd_memwb_b: got %b want 1001", {fa1, fb1}); end
        regwrite_exmem = 0; rd_memwb = 5'd7;
        #1;
        n_checks++; if ({fa1, fb1} !== 4'b0100) begin n_fail++;
            $display("FAIL fwd_memwb_a: got %b want 0100", {fa1, fb1}); end
        regwrite_exmem = 1; rd_exmem = 5'd0; regwrite_memwb = 1; rd_memwb = 5'd0;
        rs1_idex = 5'd0; rs2_idex = 5'd0;
        #1;
        n_checks++; if ({fa1, fb1} !== 4'b0000) begin n_fail++;
            $display("FAIL fwd_x0: got %b want 0000", {fa1, fb1}); end
        memread_idex = 1; rd_idex = 5'd0; rs1_ifid = 5'd0; rs1_used_ifid = 1;
        #1;
        n_checks++; if (pc1 !== 1'b1) begin n_fail++;
            $display("FAIL stall_x0: got %b want 1", pc1); end
        rd_idex = 5'd9; rs1_ifid = 5'd1; rs2_ifid = 5'd9; rs2_used_ifid = 0;
        #1;
        n_checks++; if (pc1 !== 1'b1) begin n_fail++;
            $display("FAIL rs2_unused: got %b want 1", pc1); end
        rs2_used_ifid = 1;
        #1;
        n_checks++; if ({pc1, bub1} !== 2'b01) begin n_fail++;
            $display("FAIL rs2_hazard: got %b want 01", {pc1, bub1}); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_stall();
        pulse_reset();
        set_load_use_r5();
        next_cycle();
        idle_inputs();
        #1;
        n_checks++; if (pc4 !== 1'b0) begin n_fail++;
            $display("FAIL rst4_pre: got %b want 0", pc4); end
        rst = 1;
        #1;
        n_checks++; if ({pc4, ifw4, bub4, fl4} !== 4'b1100 || sc4 !== 16'd0) begin n_fail++;
            $display("FAIL rst4_async: got %b cnt=%0d want 1100 cnt=0", {pc4, ifw4, bub4, fl4}, sc4); end
        next_cycle();
        rst = 0;
        #1;
        next_cycle();
        n_checks++; if (pc4 !== 1'b1 || sc4 !== 16'd0) begin n_fail++;
            $display("FAIL rst4_after: got pc=%b cnt=%0d want pc=1 cnt=0", pc4, sc4); end
    endtask

    task automatic test_saturate();
        pulse_reset();
        set_load_use_r5();
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            n_checks++; if (scc !== 2'((i > 3) ? 3 : i)) begin n_fail++;
                $display("FAIL sat_cycle%0d: got %0d want %0d", i, scc, (i > 3) ? 3 : i); end
        end
        n_checks++; if (sc1 !== 16'd5) begin n_fail++;
            $display("FAIL wide_count: got %0d want 5", sc1); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_lat1();
        test_lat3();
        test_branch();
        test_forwarding();
        test_reset_mid_stall();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
